// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: EX/MEM entry, data-memory response, and register-file writeback.
// With WB_BYPASS_EN defined the bus also carries the early-forwarding outputs.
interface mem_wb_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               in_valid;
  logic               in_reg_write;
  logic               in_mem_read;
  logic [31:0]        in_alu_result;
  logic [4:0]         in_dest;
  logic [31:0]        mem_rdata;
  logic               mem_ack;
  logic               flush;
  logic               stall_out;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic               retire;
  logic [COUNT_W-1:0] wb_count;
  logic               err_timeout;
`ifdef WB_BYPASS_EN
  logic               fwd_valid;
  logic [4:0]         fwd_reg;
  logic [31:0]        fwd_data;
`endif

  // Upstream pipeline / data memory side.
  modport master (
    output in_valid,
    output in_reg_write,
    output in_mem_read,
    output in_alu_result,
    output in_dest,
    output mem_rdata,
    output mem_ack,
    output flush,
    input  stall_out,
    input  rf_we,
    input  rf_waddr,
    input  rf_wdata,
    input  retire,
    input  wb_count,
`ifdef WB_BYPASS_EN
    input  fwd_valid,
    input  fwd_reg,
    input  fwd_data,
`endif
    input  err_timeout
  );

  // Writeback stage side.
  modport slave (
    input  in_valid,
    input  in_reg_write,
    input  in_mem_read,
    input  in_alu_result,
    input  in_dest,
    input  mem_rdata,
    input  mem_ack,
    input  flush,
    output stall_out,
    output rf_we,
    output rf_waddr,
    output rf_wdata,
    output retire,
    output wb_count,
`ifdef WB_BYPASS_EN
    output fwd_valid,
    output fwd_reg,
    output fwd_data,
`endif
    output err_timeout
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback controller; waits on variable-latency load data.
// Optional WB_BYPASS_EN adds combinational early-forwarding outputs on the bus.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned COUNT_W = 16
) (
  input logic     clk,
  input logic     rst_n,
  mem_wb_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 2);

  typedef enum logic [0:0] {
    StIdle,
    StWaitMem
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;
  logic               lat_reg_write_q, lat_reg_write_d;
  logic [4:0]         lat_dest_q, lat_dest_d;

  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q;
  logic [31:0]        rf_wdata_q;
  logic               retire_q;
  logic [COUNT_W-1:0] wb_count_q;
  logic               err_timeout_q;

  logic               complete;
  logic               cmp_reg_write;
  logic [4:0]         cmp_dest;
  logic [31:0]        cmp_data;
  logic               timeout_hit;
  logic               stall;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    lat_reg_write_d = lat_reg_write_q;
    lat_dest_d      = lat_dest_q;
    complete        = 1'b0;
    cmp_reg_write   = 1'b0;
    cmp_dest        = 5'd0;
    cmp_data        = 32'd0;
    timeout_hit     = 1'b0;
    stall           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && !bus.flush) begin
          if (!bus.in_mem_read) begin
            complete      = 1'b1;
            cmp_reg_write = bus.in_reg_write;
            cmp_dest      = bus.in_dest;
            cmp_data      = bus.in_alu_result;
          end else if (bus.mem_ack) begin
            complete      = 1'b1;
            cmp_reg_write = bus.in_reg_write;
            cmp_dest      = bus.in_dest;
            cmp_data      = bus.mem_rdata;
          end else begin
            // Load miss: park the entry and count this cycle as the first waited one.
            stall           = 1'b1;
            state_d         = StWaitMem;
            wait_cnt_d      = CntW'(1);
            lat_reg_write_d = bus.in_reg_write;
            lat_dest_d      = bus.in_dest;
          end
        end
      end

      StWaitMem: begin
        if (bus.mem_ack && !bus.flush) begin
          complete      = 1'b1;
          cmp_reg_write = lat_reg_write_q;
          cmp_dest      = lat_dest_q;
          cmp_data      = bus.mem_rdata;
          state_d       = StIdle;
          wait_cnt_d    = '0;
        end else begin
          stall = 1'b1;
          if (bus.flush) begin
            state_d    = StIdle;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
            if ((TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) >= TIMEOUT)) begin
              timeout_hit = 1'b1;
              state_d     = StIdle;
              wait_cnt_d  = '0;
            end
          end
        end
      end

      default: begin
        state_d    = StIdle;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Writes to $0 retire and count but never reach the register file.
  assign rf_we_d = complete && cmp_reg_write && (cmp_dest != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wait_cnt_q      <= '0;
      lat_reg_write_q <= 1'b0;
      lat_dest_q      <= 5'd0;
      rf_we_q         <= 1'b0;
      rf_waddr_q      <= 5'd0;
      rf_wdata_q      <= 32'd0;
      retire_q        <= 1'b0;
      wb_count_q      <= '0;
      err_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      lat_reg_write_q <= lat_reg_write_d;
      lat_dest_q      <= lat_dest_d;
      rf_we_q         <= rf_we_d;
      if (rf_we_d) begin
        rf_waddr_q <= cmp_dest;
        rf_wdata_q <= cmp_data;
      end
      retire_q <= complete;
      if (complete) begin
        wb_count_q <= wb_count_q + COUNT_W'(1);
      end
      err_timeout_q <= err_timeout_q | timeout_hit;
    end
  end

  // Gate with rst_n so upstream is never stalled while the stage is held in reset.
  assign bus.stall_out   = rst_n & stall;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.retire      = retire_q;
  assign bus.wb_count    = wb_count_q;
  assign bus.err_timeout = err_timeout_q;

`ifdef WB_BYPASS_EN
  assign bus.fwd_valid = rf_we_d;
  assign bus.fwd_reg   = rf_we_d ? cmp_dest : rf_waddr_q;
  assign bus.fwd_data  = rf_we_d ? cmp_data : rf_wdata_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_wb_stage;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 6;

  logic clk;
  logic rst_n;

  mem_wb_if #(.COUNT_W(CW)) bus ();

  mem_wb_stage #(
    .TIMEOUT(TO),
    .COUNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_bad;

  // Reference model state: expected registered outputs after the next edge.
  typedef struct {
    logic       rw;
    logic [4:0] dest;
    int         start;
  } pend_t;

  pend_t       pend[$];
  int          cyc;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_retire;
  int          m_count;
  logic        m_err;
  logic        m_stall;

  typedef struct {
    logic        v;
    logic        rw;
    logic        mr;
    logic        ack;
    logic        fl;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ret;
    int          e_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cyc      = 0;
    m_we     = 1'b0;
    m_waddr  = 5'd0;
    m_wdata  = 32'd0;
    m_retire = 1'b0;
    m_count  = 0;
    m_err    = 1'b0;
    m_stall  = 1'b0;
  endtask

  task automatic retire_entry(input logic rw, input logic [4:0] dest, input logic [31:0] data);
    m_retire = 1'b1;
    m_count  = (m_count + 1) % (1 << CW);
    if (rw && dest != 5'd0) begin
      m_we    = 1'b1;
      m_waddr = dest;
      m_wdata = data;
    end
  endtask

  // One cycle of the writeback rules, evaluated on the currently driven inputs.
  task automatic model_step();
    m_we     = 1'b0;
    m_retire = 1'b0;
    m_stall  = 1'b0;
    if (pend.size() == 0) begin
      if (bus.in_valid && !bus.flush) begin
        if (!bus.in_mem_read) begin
          retire_entry(bus.in_reg_write, bus.in_dest, bus.in_alu_result);
        end else if (bus.mem_ack) begin
          retire_entry(bus.in_reg_write, bus.in_dest, bus.mem_rdata);
        end else begin
          m_stall = 1'b1;
          pend.push_back('{rw: bus.in_reg_write, dest: bus.in_dest, start: cyc});
        end
      end
    end else if (bus.mem_ack && !bus.flush) begin
      retire_entry(pend[0].rw, pend[0].dest, bus.mem_rdata);
      pend.delete();
    end else begin
      m_stall = 1'b1;
      if (bus.flush) begin
        pend.delete();
      end else if (TO != 0 && (cyc - pend[0].start + 1) >= int'(TO)) begin
        m_err = 1'b1;
        pend.delete();
      end
    end
    cyc++;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic ack,
                       input logic fl);
    bus.in_valid      = v;
    bus.in_reg_write  = rw;
    bus.in_mem_read   = mr;
    bus.in_dest       = dest;
    bus.in_alu_result = alu;
    bus.mem_rdata     = rdata;
    bus.mem_ack       = ack;
    bus.flush         = fl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_regs();
    chk("rf_we", 32'(bus.rf_we), 32'(m_we));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
    chk("rf_wdata", bus.rf_wdata, m_wdata);
    chk("retire", 32'(bus.retire), 32'(m_retire));
    chk("wb_count", 32'(bus.wb_count), 32'(m_count));
    chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
  endtask

  // Called at posedge+1 with inputs driven; leaves time at the next posedge+1.
  task automatic step();
    @(negedge clk);
    model_step();
    chk("stall_out", 32'(bus.stall_out), 32'(m_stall));
`ifdef WB_BYPASS_EN
    chk("fwd_valid", 32'(bus.fwd_valid), 32'(m_we));
    if (m_we) begin
      chk("fwd_reg", 32'(bus.fwd_reg), 32'(m_waddr));
      chk("fwd_data", bus.fwd_data, m_wdata);
    end
`endif
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(bus.rf_we), 32'd0);
    chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'd0);
    chk({tag, "_wdata"}, bus.rf_wdata, 32'd0);
    chk({tag, "_retire"}, 32'(bus.retire), 32'd0);
    chk({tag, "_count"}, 32'(bus.wb_count), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_timeout), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h1, 32'h2, 1'b0, 1'b0);
    #12;
    chk_all_zero("reset");
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs();

    //   v   rw  mr  ack fl  dest   alu           rdata         we  addr   data          ret cnt
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h12345678, 32'h0,
               1'b1, 5'd8, 32'h12345678, 1'b1, 1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000AAAA, 32'h0,
               1'b0, 5'd8, 32'h12345678, 1'b1, 2};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h00000055, 32'h0,
               1'b0, 5'd8, 32'h12345678, 1'b1, 3};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 32'h00000100, 32'hCAFEF00D,
               1'b1, 5'd10, 32'hCAFEF00D, 1'b1, 4};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0BADF00D, 32'h0,
               1'b0, 5'd10, 32'hCAFEF00D, 1'b0, 4};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h11111111, 32'h0,
               1'b0, 5'd10, 32'hCAFEF00D, 1'b0, 4};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 32'h0,
               1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0, 32'h77777777,
               1'b0, 5'd31, 32'hFFFFFFFF, 1'b0, 5};

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].rw, tbl[i].mr, tbl[i].dest, tbl[i].alu, tbl[i].rdata,
            tbl[i].ack, tbl[i].fl);
      step();
      chk($sformatf("tbl%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_waddr", i), 32'(bus.rf_waddr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_wdata", i), bus.rf_wdata, tbl[i].e_data);
      chk($sformatf("tbl%0d_retire", i), 32'(bus.retire), 32'(tbl[i].e_ret));
      chk($sformatf("tbl%0d_count", i), 32'(bus.wb_count), 32'(tbl[i].e_cnt));
    end

    // Load with a 3-cycle ack delay.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h40, 32'h0, 1'b0, 1'b0);
      else       drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0);
      #1;
      chk($sformatf("ld3_stall%0d", i), 32'(bus.stall_out), (i < 3) ? 32'd1 : 32'd0);
      step();
    end
    chk("ld3_we", 32'(bus.rf_we), 32'd1);
    chk("ld3_waddr", 32'(bus.rf_waddr), 32'd9);
    chk("ld3_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("ld3_retire", 32'(bus.retire), 32'd1);

    // Flush and ack together while waiting: flush wins.
    drive(1'b1, 1'b1, 1'b1, 5'd13, 32'h80, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd13, 32'h80, 32'h55AA55AA, 1'b1, 1'b1);
    step();
    chk("flw_we", 32'(bus.rf_we), 32'd0);
    chk("flw_retire", 32'(bus.retire), 32'd0);
    chk("flw_wdata", bus.rf_wdata, 32'hDEADBEEF);
    drive_idle();
    #1;
    chk("flw_stall_after", 32'(bus.stall_out), 32'd0);
    step();

    // Load that never gets an ack: times out after TO stalled cycles.
    for (int i = 0; i < int'(TO); i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd14, 32'hC0, 32'h0, 1'b0, 1'b0);
      #1;
      chk($sformatf("to_stall%0d", i), 32'(bus.stall_out), 32'd1);
      chk($sformatf("to_err_pre%0d", i), 32'(bus.err_timeout), 32'd0);
      step();
    end
    chk("to_err", 32'(bus.err_timeout), 32'd1);
    chk("to_we", 32'(bus.rf_we), 32'd0);
    chk("to_retire", 32'(bus.retire), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 5'd15, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0);
    #1;
    chk("to_stall_after", 32'(bus.stall_out), 32'd0);
    step();
    chk("to_alu_we", 32'(bus.rf_we), 32'd1);
    chk("to_alu_wdata", bus.rf_wdata, 32'h0F0F0F0F);
    chk("to_err_sticky", 32'(bus.err_timeout), 32'd1);
    drive_idle();
    step();
    chk("to_err_sticky2", 32'(bus.err_timeout), 32'd1);

    // Reset asserted while a load is outstanding.
    drive(1'b1, 1'b1, 1'b1, 5'd20, 32'h100, 32'h0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstmid");
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h99999999, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_regs();
    step();
    step();
    chk("rstmid_count", 32'(bus.wb_count), 32'd0);
    chk("rstmid_we", 32'(bus.rf_we), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 1)), d, $urandom(), $urandom(),
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 11) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
